// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM whose outputs decode from the
// current state, with FETCH/MEM_RD/MEM_WR gated by the memory handshake.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_beq,
    output logic       pc_write_bne,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JR       = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_next;
    logic       w_is_r;
    logic       w_is_jr;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [2:0] w_exec_alu_op;

    assign w_is_r  = (opcode == OP_R);
    assign w_is_jr = w_is_r && (funct == FN_JR);

    always_comb begin
        case (opcode)
            OP_R:    w_exec_alu_op = 3'b010;
            OP_ANDI: w_exec_alu_op = 3'b100;
            OP_ORI:  w_exec_alu_op = 3'b101;
            OP_SLTI: w_exec_alu_op = 3'b110;
            default: w_exec_alu_op = 3'b000;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
                    OP_R:                             w_next = w_is_jr ? S_JR : S_EXEC;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_EXEC;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J:                             w_next = S_JUMP;
                    OP_JAL:                           w_next = S_JAL;
                    default:                          w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     w_next = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            // Unused encodings are treated as a fault rather than silently resumed
            default:    w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        pc_src       = 2'd0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        w_mem_write  = 1'b0;
        ir_write     = 1'b0;
        w_reg_write  = 1'b0;
        reg_dst      = 2'd0;
        mem_to_reg   = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 2'd1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = w_is_r ? 2'd0 : 2'd2;
                alu_op    = w_exec_alu_op;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = w_is_r ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = 3'b001;
                pc_src       = 2'd1;
                pc_write_beq = (opcode == OP_BEQ);
                pc_write_bne = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            S_JAL: begin
                pc_write    = 1'b1;
                pc_src      = 2'd2;
                w_reg_write = 1'b1;
                reg_dst     = 2'd2;
                mem_to_reg  = 2'd2;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'd3;
            end
            default: ;
        endcase
    end

    // A reset arriving mid-instruction must not let a writeback slip through
    assign reg_write = w_reg_write & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign illegal   = r_illegal;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; outputs are sampled 1 ns
// after each rising edge against hand-computed expectations.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_beq, pc_write_bne;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    int n_vectors = 0;
    int n_miscompares = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_beq(pc_write_beq),
        .pc_write_bne(pc_write_bne), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    endtask

    task automatic tick_state(input string tag, input logic [3:0] exp);
        tick();
        check(tag, {28'd0, state}, {28'd0, exp});
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;
        tick(); tick();
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        check("fetch_mem_read", {31'd0, mem_read}, 32'd1);
        check("fetch_ir_write", {31'd0, ir_write}, 32'd1);
        check("fetch_pc_write", {31'd0, pc_write}, 32'd1);
        check("fetch_alu_src_b", {30'd0, alu_src_b}, 32'd1);
        check("fetch_iord", {31'd0, iord}, 32'd0);

        // lw, no waits: 0,1,2,3,4,0
        opcode = 6'b100011;
        tick_state("lw_s1", 4'd1);
        check("dec_alu_src_b", {30'd0, alu_src_b}, 32'd3);
        tick_state("lw_s2", 4'd2);
        check("maddr_alu_src_b", {30'd0, alu_src_b}, 32'd2);
        check("maddr_alu_src_a", {31'd0, alu_src_a}, 32'd1);
        tick_state("lw_s3", 4'd3);
        check("mrd_mem_read", {31'd0, mem_read}, 32'd1);
        check("mrd_iord", {31'd0, iord}, 32'd1);
        tick_state("lw_s4", 4'd4);
        check("mwb_reg_write", {31'd0, reg_write}, 32'd1);
        check("mwb_reg_dst", {30'd0, reg_dst}, 32'd0);
        check("mwb_mem_to_reg", {30'd0, mem_to_reg}, 32'd1);
        tick_state("lw_s0", 4'd0);
        $display("txn lw complete at %0t", $time);

        // FETCH stall: nothing latched while memory is busy
        mem_ready = 1'b0;
        #1;
        check("fstall_ir_write", {31'd0, ir_write}, 32'd0);
        check("fstall_pc_write", {31'd0, pc_write}, 32'd0);
        tick_state("fstall_hold", 4'd0);
        mem_ready = 1'b1;
        $display("txn fetch_stall complete at %0t", $time);

        // sw with three wait cycles in MEM_WR
        opcode = 6'b101011;
        tick_state("sw_s1", 4'd1);
        tick_state("sw_s2", 4'd2);
        mem_ready = 1'b0;
        tick_state("sw_s5", 4'd5);
        for (int i = 0; i < 4; i++) begin
            check("sw_mem_write", {31'd0, mem_write}, 32'd1);
            check("sw_iord", {31'd0, iord}, 32'd1);
            check("sw_wr_state", {28'd0, state}, 32'd5);
            mem_ready = (i == 3);
            tick();
        end
        check("sw_back_fetch", {28'd0, state}, 32'd0);
        $display("txn sw_wait3 complete at %0t", $time);

        // R-type add
        opcode = 6'b000000; funct = 6'b100000;
        tick_state("r_s1", 4'd1);
        tick_state("r_s6", 4'd6);
        check("r_alu_op", {29'd0, alu_op}, 32'd2);
        check("r_alu_src_b", {30'd0, alu_src_b}, 32'd0);
        tick_state("r_s7", 4'd7);
        check("r_reg_dst", {30'd0, reg_dst}, 32'd1);
        check("r_reg_write", {31'd0, reg_write}, 32'd1);
        tick_state("r_s0", 4'd0);
        $display("txn rtype complete at %0t", $time);

        // jr
        funct = 6'b001000;
        tick_state("jr_s1", 4'd1);
        tick_state("jr_s11", 4'd11);
        check("jr_pc_src", {30'd0, pc_src}, 32'd3);
        check("jr_pc_write", {31'd0, pc_write}, 32'd1);
        tick_state("jr_s0", 4'd0);
        $display("txn jr complete at %0t", $time);

        // immediate ALU ops: opcode / expected alu_op
        begin
            logic [5:0] imm_ops [4];
            logic [2:0] imm_alu [4];
            imm_ops = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};
            imm_alu = '{3'b000, 3'b110, 3'b100, 3'b101};
            for (int k = 0; k < 4; k++) begin
                opcode = imm_ops[k];
                tick_state("imm_s1", 4'd1);
                tick_state("imm_s6", 4'd6);
                check("imm_alu_op", {29'd0, alu_op}, {29'd0, imm_alu[k]});
                check("imm_alu_src_b", {30'd0, alu_src_b}, 32'd2);
                tick_state("imm_s7", 4'd7);
                check("imm_reg_dst", {30'd0, reg_dst}, 32'd0);
                tick_state("imm_s0", 4'd0);
                $display("txn imm op=%b complete at %0t", imm_ops[k], $time);
            end
        end

        // beq then bne
        for (int b = 0; b < 2; b++) begin
            opcode = (b == 0) ? 6'b000100 : 6'b000101;
            tick_state("br_s1", 4'd1);
            tick_state("br_s8", 4'd8);
            check("br_alu_op", {29'd0, alu_op}, 32'd1);
            check("br_pc_src", {30'd0, pc_src}, 32'd1);
            check("br_beq", {31'd0, pc_write_beq}, (b == 0) ? 32'd1 : 32'd0);
            check("br_bne", {31'd0, pc_write_bne}, (b == 0) ? 32'd0 : 32'd1);
            check("br_pc_write", {31'd0, pc_write}, 32'd0);
            tick_state("br_s0", 4'd0);
            $display("txn branch op=%b complete at %0t", opcode, $time);
        end

        // j
        opcode = 6'b000010;
        tick_state("j_s1", 4'd1);
        tick_state("j_s9", 4'd9);
        check("j_pc_src", {30'd0, pc_src}, 32'd2);
        check("j_pc_write", {31'd0, pc_write}, 32'd1);
        check("j_reg_write", {31'd0, reg_write}, 32'd0);
        tick_state("j_s0", 4'd0);
        $display("txn j complete at %0t", $time);

        // jal
        opcode = 6'b000011;
        tick_state("jal_s1", 4'd1);
        tick_state("jal_s10", 4'd10);
        check("jal_reg_dst", {30'd0, reg_dst}, 32'd2);
        check("jal_mem_to_reg", {30'd0, mem_to_reg}, 32'd2);
        check("jal_pc_write", {31'd0, pc_write}, 32'd1);
        check("jal_reg_write", {31'd0, reg_write}, 32'd1);
        tick_state("jal_s0", 4'd0);
        $display("txn jal complete at %0t", $time);

        // illegal opcode traps and stays trapped
        opcode = 6'b111111;
        tick_state("trap_s1", 4'd1);
        check("trap_pre_illegal", {31'd0, illegal}, 32'd0);
        for (int t = 0; t < 10; t++) begin
            tick_state("trap_hold", 4'd15);
            check("trap_illegal", {31'd0, illegal}, 32'd1);
            check("trap_mem_read", {31'd0, mem_read}, 32'd0);
        end
        reset = 1'b1;
        tick_state("trap_rst", 4'd0);
        check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        $display("txn trap complete at %0t", $time);

        // reset during a MEM_RD wait
        opcode = 6'b100011;
        tick_state("rrd_s1", 4'd1);
        tick_state("rrd_s2", 4'd2);
        mem_ready = 1'b0;
        tick_state("rrd_s3", 4'd3);
        reset = 1'b1;
        #1;
        check("rrd_reg_write_a", {31'd0, reg_write}, 32'd0);
        tick_state("rrd_fetch", 4'd0);
        check("rrd_reg_write_b", {31'd0, reg_write}, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        $display("txn reset_in_mem_rd complete at %0t", $time);

        // reset sampled in MEM_WB must suppress the writeback
        tick_state("rwb_s1", 4'd1);
        tick_state("rwb_s2", 4'd2);
        tick_state("rwb_s3", 4'd3);
        tick_state("rwb_s4", 4'd4);
        reset = 1'b1;
        #1;
        check("rwb_reg_write", {31'd0, reg_write}, 32'd0);
        tick_state("rwb_fetch", 4'd0);
        reset = 1'b0;
        $display("txn reset_in_mem_wb complete at %0t", $time);

        // reset sampled in MEM_WR must suppress the store
        opcode = 6'b101011;
        tick_state("rwr_s1", 4'd1);
        tick_state("rwr_s2", 4'd2);
        mem_ready = 1'b0;
        tick_state("rwr_s5", 4'd5);
        reset = 1'b1;
        #1;
        check("rwr_mem_write", {31'd0, mem_write}, 32'd0);
        tick_state("rwr_fetch", 4'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        $display("txn reset_in_mem_wr complete at %0t", $time);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have a single clock and a single reset; the reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 opcode  input  6  instruction bits [31:26]; valid from the IR in DECODE and later states.
REQ-005 funct  input  6  instruction bits [5:0]; used only when opcode=000000.
REQ-006 mem_ready  input  1  memory completion; the current access finishes in a cycle where it is 1.
REQ-007 pc_write  output  1  unconditional PC load.
REQ-008 pc_write_beq  output  1  PC load if ALU zero=1.
REQ-009 pc_write_bne  output  1  PC load if ALU zero=0.
REQ-010 pc_src  output  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=rs.
REQ-011 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-012 mem_read  output  1  memory read request.
REQ-013 mem_write  output  1  memory write request.
REQ-014 ir_write  output  1  IR load.
REQ-015 reg_write  output  1  register file write.
REQ-016 reg_dst  output  2  write register select: 0=rt, 1=rd, 2=$31.
REQ-017 mem_to_reg  output  2  write data select: 0=ALUOut, 1=MDR, 2=PC.
REQ-018 alu_src_a  output  1  ALU A select: 0=PC, 1=rs.
REQ-019 alu_src_b  output  2  ALU B select: 0=rt, 1=constant 4, 2=sign-extended immediate, 3=sign-extended immediate shifted left by 2.
REQ-020 alu_op  output  3  ALU operation encoding.
REQ-021 illegal  output  1  sticky illegal-opcode flag.
REQ-022 state  output  4  current state code, for debug.

Function
REQ-023 Supported opcodes SHALL be: R=000000, j=000010, jal=000011, beq=000100, bne=000101, addi=001000, slti=001010, andi=001100, ori=001101, lw=100011, sw=101011.
REQ-024 jr SHALL be decoded as opcode=000000 with funct=001000.
REQ-025 alu_op SHALL be: add=000 (lw, sw, addi, FETCH, DECODE), sub=001 (beq, bne), funct-decode=010 (R), and=100 (andi), or=101 (ori), slt=110 (slti).
REQ-026 State codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, JAL=10, JR=11, TRAP=15.
REQ-027 Outputs SHALL be Moore decoded from state, except in FETCH, MEM_RD and MEM_WR, which gate on mem_ready; every output not listed for a state SHALL be 0.
REQ-028 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=000 and pc_src=0.
REQ-029 In FETCH, ir_write and pc_write SHALL equal mem_ready; the block SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-030 DECODE SHALL assert alu_src_a=0, alu_src_b=3 and alu_op=000 (branch target into ALUOut), then transition as follows.
REQ-031 From DECODE: lw/sw->MEM_ADDR, R (not jr)/addi/slti/andi/ori->EXEC, jr->JR, beq/bne->BRANCH, j->JUMP, jal->JAL, any other opcode->TRAP.
REQ-032 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=2 and alu_op=000, then go to MEM_RD for lw or MEM_WR for sw.
REQ-033 MEM_RD SHALL assert mem_read=1 and iord=1, hold while mem_ready=0, and go to MEM_WB when mem_ready=1.
REQ-034 MEM_WB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-035 MEM_WR SHALL assert mem_write=1 and iord=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-036 EXEC SHALL assert alu_src_a=1 and alu_op per REQ-025, with alu_src_b=0 for R-type and 2 otherwise, then go to ALU_WB.
REQ-037 ALU_WB SHALL assert reg_write=1 and mem_to_reg=0, with reg_dst=1 for R-type and 0 otherwise, then go to FETCH.
REQ-038 BRANCH SHALL assert alu_src_a=1, alu_src_b=0, alu_op=001 and pc_src=1, with pc_write_beq=1 for beq or pc_write_bne=1 for bne, then go to FETCH.
REQ-039 JUMP SHALL assert pc_write=1 and pc_src=2, then go to FETCH.
REQ-040 JAL SHALL assert pc_write=1, pc_src=2, reg_write=1, reg_dst=2 and mem_to_reg=2 (PC already incremented), then go to FETCH.
REQ-041 JR SHALL assert pc_write=1 and pc_src=3, then go to FETCH.
REQ-042 TRAP SHALL set illegal=1, drive all other control outputs 0, and remain in TRAP until reset.
REQ-043 Cycle counts with mem_ready=1 throughout SHALL be: lw=5, sw=4, R/immediate=4, beq/bne/j/jal/jr=3; each memory wait cycle SHALL add exactly one cycle.
REQ-044 Only one memory request SHALL be active at any time; mem_read and mem_write SHALL never be 1 together.

Reset
REQ-045 With reset=1 at a clock edge, the next state SHALL be FETCH and illegal SHALL be 0, overriding any transition, including reset asserted mid-instruction or during a memory wait.
REQ-046 Outputs SHALL reflect FETCH in the cycle after the reset edge; no reg_write or mem_write SHALL occur in the cycle reset is sampled.

Verification
REQ-047 Reset, then fetch with mem_ready=1, then opcode=100011 -> state sequence 0,1,2,3,4,0, with reg_write=1, reg_dst=0 and mem_to_reg=1 in state 4.
REQ-048 sw with mem_ready=0 for 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, iord=1, then return to FETCH.
REQ-049 opcode=000000 with funct=100000, then with funct=001000 -> R-type gives states 0,1,6,7 with alu_op=010 and reg_dst=1; jr gives states 0,1,11 with pc_src=3 and pc_write=1.
REQ-050 beq and bne -> BRANCH with alu_op=001 and pc_src=1; only pc_write_beq=1 (beq) or only pc_write_bne=1 (bne).
REQ-051 jal -> states 0,1,10 with reg_dst=2, mem_to_reg=2 and pc_write=1; opcode=111111 -> TRAP with illegal=1 held for 10 cycles, then cleared by reset.
REQ-052 Reset asserted during MEM_RD while mem_ready=0 -> state=FETCH on the next edge, with no reg_write pulse.
